// File: rtl/sif_pkg.sv
// Shared constants and state encodings for the serial-interface scheduler.
// Imported by the arbiter, the interface and the scheduler top.
package sif_pkg;

  localparam int SIF_NREQ        = 4;
  localparam int SIF_DW          = 8;
  localparam int SIF_EN_HIGH     = 4;
  localparam int SIF_XFER_CYCLES = 24;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;

  // Requester-ID width; a single requester still needs one bit.
  function automatic int sif_idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sif_sched_if.sv
// Requester/transmitter bundle of the scheduler.
// master = requester side, slave = scheduler.
interface sif_sched_if
  import sif_pkg::*;
#(
  parameter int NREQ = SIF_NREQ,
  parameter int DW   = SIF_DW,
  parameter int IW   = sif_idw(NREQ)
);

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic               busy;
  logic               sif_en;
  logic [DW-1:0]      sif_data;
  logic               done;
  logic [IW-1:0]      done_id;

  modport master (
    output req,
    output req_data,
    input  gnt,
    input  busy,
    input  sif_en,
    input  sif_data,
    input  done,
    input  done_id
  );

  modport slave (
    input  req,
    input  req_data,
    output gnt,
    output busy,
    output sif_en,
    output sif_data,
    output done,
    output done_id
  );

endinterface

// File: rtl/sif_rr_arb.sv
// Combinational round-robin picker: first set request
// at or above the pointer, wrapping around.
module sif_rr_arb
  import sif_pkg::*;
#(
  parameter int NREQ = SIF_NREQ,
  parameter int IW   = sif_idw(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic            o_any,
  output logic [IW-1:0]   o_idx,
  output logic [NREQ-1:0] o_onehot
);

  localparam logic [IW:0] W_N = (IW+1)'(NREQ);

  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [IW-1:0]     w_off;
  logic [IW:0]       w_sum;

  // Rotate so the pointer lands at bit 0, then find the lowest set bit.
  assign w_dbl = {i_req, i_req};
  assign w_rot = w_dbl[i_ptr +: NREQ];

  always_comb begin
    w_off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = IW'(k);
    end
  end

  assign o_any = |i_req;
  assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
  assign o_idx = (w_sum >= W_N) ? IW'(w_sum - W_N)
                                : w_sum[IW-1:0];

  always_comb begin
    o_onehot = '0;
    for (int k = 0; k < NREQ; k++) begin
      o_onehot[k] = o_any && (o_idx == IW'(k));
    end
  end

endmodule

// File: rtl/sif_sched.sv
// Round-robin scheduler sharing one serial-interface transmitter;
// grants a requester, drives enable/data and times the transfer window.
module sif_sched
  import sif_pkg::*;
#(
  parameter int NREQ        = SIF_NREQ,
  parameter int DW          = SIF_DW,
  parameter int EN_HIGH     = SIF_EN_HIGH,
  parameter int XFER_CYCLES = SIF_XFER_CYCLES
) (
  input  logic      clk,
  input  logic      rst,
  sif_sched_if.slave bus
);

  localparam int IW = sif_idw(NREQ);
  localparam int CW = $clog2(XFER_CYCLES + 1);

  localparam logic [CW-1:0] C_EN = CW'(EN_HIGH);
  localparam logic [CW-1:0] C_XF = CW'(XFER_CYCLES);

  logic [1:0]      r_state;
  logic [IW-1:0]   r_ptr;
  logic [CW-1:0]   r_cnt;
  logic [IW-1:0]   r_id;
  logic [NREQ-1:0] r_gnt;
  logic            r_busy;
  logic            r_en;
  logic [DW-1:0]   r_data;
  logic            r_done;
  logic [IW-1:0]   r_done_id;

  logic            w_any;
  logic [IW-1:0]   w_idx;
  logic [NREQ-1:0] w_onehot;
  logic [IW-1:0]   w_ptr_nxt;
  logic [DW-1:0]   w_sel;

  sif_rr_arb #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .i_req    (bus.req),
    .i_ptr    (r_ptr),
    .o_any    (w_any),
    .o_idx    (w_idx),
    .o_onehot (w_onehot)
  );

  assign w_ptr_nxt = (w_idx == IW'(NREQ - 1)) ? '0
                                              : w_idx + 1'b1;

  always_comb begin
    w_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_idx == IW'(k)) w_sel = bus.req_data[k*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_id      <= '0;
      r_gnt     <= '0;
      r_busy    <= 1'b0;
      r_en      <= 1'b0;
      r_data    <= '0;
      r_done    <= 1'b0;
      r_done_id <= '0;
    end else begin
      r_gnt  <= '0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_onehot;
            r_data  <= w_sel;
            r_en    <= 1'b1;
            r_busy  <= 1'b1;
            r_id    <= w_idx;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= CW'(1);
            r_state <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == C_EN) begin
            r_en    <= 1'b0;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == C_XF) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_done_id <= r_id;
            r_cnt     <= '0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt      = r_gnt;
  assign bus.busy     = r_busy;
  assign bus.sif_en   = r_en;
  assign bus.sif_data = r_data;
  assign bus.done     = r_done;
  assign bus.done_id  = r_done_id;

  a_gnt_1hot: assert property (
    @(posedge clk) disable iff (rst) $onehot0(r_gnt)
  );

  a_en_in_busy: assert property (
    @(posedge clk) disable iff (rst) r_en |-> r_busy
  );

endmodule

// File: tb/tb_sif_sched.sv
// Scoreboard bench for sif_sched: expected grants are queued
// as requests are driven and checked when the DUT grants.
module tb_sif_sched;
  import sif_pkg::*;

  localparam int NR = 4;
  localparam int EH = 4;
  localparam int XC = 24;

  typedef struct {
    int         id;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sif_sched_if #(.NREQ(NR), .DW(8)) bus ();

  sif_sched #(
    .NREQ        (NR),
    .DW          (8),
    .EN_HIGH     (EH),
    .XFER_CYCLES (XC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_done = 0;

  exp_t exp_q[$];
  int   gcyc[$];
  int   dcyc[$];

  logic [NR-1:0] hold = '0;
  bit            act = 1'b0;
  int            cur_id = 0;
  logic [7:0]    cur_data = '0;
  int            en_n = 0;
  int            busy_n = 0;
  bit            saw3 = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp_v);
    n_chk++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp_v, cyc);
    end
  endtask

  task automatic mon();
    exp_t e;
    if (bus.gnt != '0) begin
      chk("gnt_1hot", 32'($onehot(bus.gnt)), 1);
      chk("gnt_pend", 32'(exp_q.size() != 0), 1);
      chk("gnt_overlap", 32'(act), 0);
      chk("gnt_en_busy", {bus.sif_en, bus.busy}, 2'b11);
      if (bus.gnt[3]) saw3 = 1'b1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("gnt_id", bus.gnt, 32'(1) << e.id);
        chk("gnt_data", bus.sif_data, e.data);
        cur_id   = e.id;
        cur_data = e.data;
      end else begin
        cur_id   = -1;
        cur_data = '0;
      end
      act    = 1'b1;
      en_n   = 1;
      busy_n = 1;
      gcyc.push_back(cyc);
    end else if (act) begin
      if (bus.done) begin
        chk("done_id", bus.done_id, cur_id);
        chk("en_cycles", en_n, EH);
        chk("busy_cycles", busy_n, XC);
        chk("done_busy", {bus.sif_en, bus.busy}, 0);
        act = 1'b0;
        n_done++;
        dcyc.push_back(cyc);
      end else begin
        if (bus.sif_en) en_n++;
        if (bus.busy) busy_n++;
        chk("data_hold", bus.sif_data, cur_data);
      end
    end else begin
      chk("done_spur", bus.done, 0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (rst) act = 1'b0;
    else mon();
    for (int i = 0; i < NR; i++) begin
      if (bus.gnt[i] && !hold[i]) bus.req[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_en", bus.sif_en, 0);
    chk("rst_data", bus.sif_data, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_done_id", bus.done_id, 0);
    rst = 1'b0;
    exp_q.delete();
    gcyc.delete();
    dcyc.delete();
    n_done = 0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int b = budget;
    while (n_done < target && b > 0) begin
      step();
      b--;
    end
    chk("wait_done", n_done, target);
  endtask

  task automatic put(input int id, input logic [7:0] d);
    bus.req[id] = 1'b1;
    bus.req_data[id*8 +: 8] = d;
  endtask

  task automatic push(input int id, input logic [7:0] d);
    exp_t e;
    e.id   = id;
    e.data = d;
    exp_q.push_back(e);
  endtask

  initial begin
    int t0;
    int b;
    logic [7:0] bytes [4];
    bus.req      = '0;
    bus.req_data = '0;
    do_reset();

    // T1: single request, window timing
    t0 = cyc;
    put(0, 8'hA5);
    push(0, 8'hA5);
    step();
    chk("t1_gnt_cyc", gcyc.size() > 0 ? gcyc[0] - t0 : -1, 1);
    chk("t1_gnt", bus.gnt, 4'b0001);
    for (int c = 2; c <= 4; c++) begin
      step();
      chk("t1_en_hi", bus.sif_en, 1);
    end
    step();
    chk("t1_en_lo", {bus.sif_en, bus.busy}, 2'b01);
    wait_done(1, 40);
    chk("t1_done_cyc", dcyc.size() > 0 ? dcyc[0] - t0 : -1, 25);

    // T2: all four requesting, rotating order
    do_reset();
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      put(i, bytes[i]);
      push(i, bytes[i]);
    end
    wait_done(4, 140);
    for (int k = 0; k < 4; k++) begin
      chk("t2_gnt_cyc", gcyc.size() > k ? gcyc[k] - t0 : -1, 1 + 25 * k);
      chk("t2_done_cyc", dcyc.size() > k ? dcyc[k] - t0 : -1, 25 + 25 * k);
    end

    // T3: req0 held continuously, req2 competing
    do_reset();
    hold[0] = 1'b1;
    put(0, 8'h0A);
    put(2, 8'h2B);
    push(0, 8'h0A);
    push(2, 8'h2B);
    push(0, 8'h0A);
    push(2, 8'h2B);
    b = 140;
    while (gcyc.size() < 4 && b > 0) begin
      if (gcyc.size() == 2) bus.req[2] = 1'b1;
      step();
      b--;
    end
    hold = '0;
    bus.req = '0;
    wait_done(4, 40);
    for (int k = 1; k < 4; k++) begin
      chk("t3_gap", gcyc.size() > k ? gcyc[k] - gcyc[k-1] : -1, 25);
    end

    // T4: reset in the middle of a transfer
    do_reset();
    t0 = cyc;
    put(0, 8'hC3);
    push(0, 8'hC3);
    while (cyc < t0 + 10) step();
    chk("t4_busy_pre", bus.busy, 1);
    do_reset();
    put(1, 8'h61);
    put(2, 8'h62);
    push(1, 8'h61);
    push(2, 8'h62);
    step();
    chk("t4_gnt1", bus.gnt, 4'b0010);
    wait_done(2, 70);

    // T5: withdrawn request, request in the done cycle
    do_reset();
    saw3 = 1'b0;
    put(0, 8'h5A);
    push(0, 8'h5A);
    step();
    for (int c = 0; c < 4; c++) step();
    put(3, 8'h77);
    for (int c = 0; c < 3; c++) step();
    bus.req[3] = 1'b0;
    b = 40;
    while (!bus.done && b > 0) begin
      step();
      b--;
    end
    chk("t5_done_seen", bus.done, 1);
    put(1, 8'h99);
    push(1, 8'h99);
    step();
    chk("t5_gnt1", bus.gnt, 4'b0010);
    wait_done(2, 40);
    for (int c = 0; c < 3; c++) step();
    chk("t5_no_gnt3", saw3, 0);

    // T6: req_data changes after grant
    do_reset();
    put(0, 8'h3C);
    push(0, 8'h3C);
    step();
    chk("t6_gnt", bus.gnt, 4'b0001);
    bus.req_data[7:0] = 8'hFF;
    wait_done(1, 40);
    step();
    chk("t6_after", bus.sif_data, 8'h3C);
    chk("t6_idle", bus.busy, 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
